// File: rtl/decode_pkg.sv
// Shared decode constants: opcodes, instruction-type encoding, field-valid
// bit positions and the per-type field-valid mask.
package decode_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    TYPE_R   = 3'd0,
    TYPE_I   = 3'd1,
    TYPE_S   = 3'd2,
    TYPE_B   = 3'd3,
    TYPE_U   = 3'd4,
    TYPE_J   = 3'd5,
    TYPE_SYS = 3'd6,
    TYPE_ILL = 3'd7
  } instr_type_e;

  localparam int unsigned FV_RD    = 0;
  localparam int unsigned FV_RS1   = 1;
  localparam int unsigned FV_RS2   = 2;
  localparam int unsigned FV_FUNC3 = 3;
  localparam int unsigned FV_FUNC7 = 4;
  localparam int unsigned FV_IMM   = 5;
  localparam int unsigned FV_W     = 6;

  // Everything about a decoded instruction except the XLEN-wide imm/pc.
  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [5:0]  field_valid;
    instr_type_e itype;
    logic        illegal;
  } dec_fields_t;

  function automatic logic [FV_W-1:0] fv_mask(input instr_type_e t);
    logic [FV_W-1:0] m;
    m = '0;
    case (t)
      TYPE_R: begin
        m[FV_RD] = 1'b1; m[FV_RS1] = 1'b1; m[FV_RS2] = 1'b1;
        m[FV_FUNC3] = 1'b1; m[FV_FUNC7] = 1'b1;
      end
      TYPE_I, TYPE_SYS: begin
        m[FV_RD] = 1'b1; m[FV_RS1] = 1'b1; m[FV_FUNC3] = 1'b1; m[FV_IMM] = 1'b1;
      end
      TYPE_S, TYPE_B: begin
        m[FV_RS1] = 1'b1; m[FV_RS2] = 1'b1; m[FV_FUNC3] = 1'b1; m[FV_IMM] = 1'b1;
      end
      TYPE_U, TYPE_J: begin
        m[FV_RD] = 1'b1; m[FV_IMM] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Upstream/downstream handshake and decoded-output bundle for decode_stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [XLEN-1:0] out_imm;
  logic [5:0]      out_field_valid;
  logic [2:0]      out_type;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_func3, out_func7, out_imm, out_field_valid, out_type, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_func3, out_func7, out_imm, out_field_valid, out_type, out_illegal
  );
endinterface

// File: rtl/decode_logic.sv
// Pure combinational RV32I(+M) field/immediate/type/legality decoder.
module decode_logic
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned M_EXT = 1
) (
  input  logic [31:0]     instr_i,
  output dec_fields_t     fields_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i_fmt;
  logic [31:0] imm_s_fmt;
  logic [31:0] imm_b_fmt;
  logic [31:0] imm_u_fmt;
  logic [31:0] imm_j_fmt;
  logic [31:0] imm32;
  logic        ill;
  instr_type_e itype;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  assign imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_fmt = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_fmt = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
  assign imm_u_fmt = {instr_i[31:12], 12'h000};
  assign imm_j_fmt = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};

  // Classify opcode, pick immediate format and apply legality rules.
  always_comb begin
    itype = TYPE_ILL;
    imm32 = '0;
    ill   = 1'b0;
    case (opcode)
      OPC_OP: begin
        itype = TYPE_R;
        if (f7 == 7'b0000000) begin
          ill = 1'b0;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          ill = 1'b0;
        end else if (f7 == 7'b0000001 && M_EXT != 0) begin
          ill = 1'b0;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        itype = TYPE_I;
        imm32 = imm_i_fmt;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // RV64 shamt is 6 bits, so only instr[31:26] carry the shift kind.
          if (XLEN == 64) begin
            ill = !((instr_i[31:26] == 6'b000000) ||
                    (f3 == 3'b101 && instr_i[31:26] == 6'b010000));
          end else begin
            ill = !((instr_i[31:25] == 7'b0000000) ||
                    (f3 == 3'b101 && instr_i[31:25] == 7'b0100000));
          end
        end
      end
      OPC_LOAD, OPC_JALR: begin
        itype = TYPE_I;
        imm32 = imm_i_fmt;
      end
      OPC_STORE: begin
        itype = TYPE_S;
        imm32 = imm_s_fmt;
      end
      OPC_BRANCH: begin
        itype = TYPE_B;
        imm32 = imm_b_fmt;
      end
      OPC_LUI, OPC_AUIPC: begin
        itype = TYPE_U;
        imm32 = imm_u_fmt;
      end
      OPC_JAL: begin
        itype = TYPE_J;
        imm32 = imm_j_fmt;
      end
      OPC_SYSTEM, OPC_MISC_MEM: begin
        itype = TYPE_SYS;
        imm32 = imm_i_fmt;
      end
      default: ill = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) begin
      ill = 1'b1;
    end
    if (ill) begin
      itype = TYPE_ILL;
      imm32 = '0;
    end
  end

  // Raw register/func slices always pass through; validity says which matter.
  always_comb begin
    fields_o.rd          = instr_i[11:7];
    fields_o.rs1         = instr_i[19:15];
    fields_o.rs2         = instr_i[24:20];
    fields_o.func3       = f3;
    fields_o.func7       = f7;
    fields_o.field_valid = ill ? '0 : fv_mask(itype);
    fields_o.itype       = itype;
    fields_o.illegal     = ill;
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Decode stage: input-side decoder feeding a two-entry (main + skid) buffer
// with registered in_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned M_EXT = 1
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);

  dec_fields_t     dec_f;
  logic [XLEN-1:0] dec_imm;

  decode_logic #(
    .XLEN  (XLEN),
    .M_EXT (M_EXT)
  ) u_decode_logic (
    .instr_i  (bus.in_instr),
    .fields_o (dec_f),
    .imm_o    (dec_imm)
  );

  logic            main_v_q, main_v_d;
  logic            skid_v_q, skid_v_d;
  dec_fields_t     main_f_q, main_f_d;
  dec_fields_t     skid_f_q, skid_f_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            rdy_q, rdy_d;
  logic            in_ready;
  logic            accept;
  logic            drain;

  // rdy_q is preset during reset so in_ready rises in the first cycle after
  // rst drops; the rst gate keeps it low while reset is held.
  assign in_ready = rdy_q & ~rst;
  assign accept   = bus.in_valid & in_ready;
  assign drain    = main_v_q & bus.out_ready;

  // Skid buffer next-state: refill main from skid first, else from input.
  always_comb begin
    main_v_d   = main_v_q;
    skid_v_d   = skid_v_q;
    main_f_d   = main_f_q;
    skid_f_d   = skid_f_q;
    main_imm_d = main_imm_q;
    skid_imm_d = skid_imm_q;
    main_pc_d  = main_pc_q;
    skid_pc_d  = skid_pc_q;
    if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || drain) begin
      if (skid_v_q) begin
        main_v_d   = 1'b1;
        main_f_d   = skid_f_q;
        main_imm_d = skid_imm_q;
        main_pc_d  = skid_pc_q;
        skid_v_d   = 1'b0;
      end else if (accept) begin
        main_v_d   = 1'b1;
        main_f_d   = dec_f;
        main_imm_d = dec_imm;
        main_pc_d  = bus.in_pc;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_v_d   = 1'b1;
      skid_f_d   = dec_f;
      skid_imm_d = dec_imm;
      skid_pc_d  = bus.in_pc;
    end
    rdy_d = ~skid_v_d;
  end

  // State registers with synchronous reset clearing entries and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      main_f_q   <= '0;
      skid_f_q   <= '0;
      main_imm_q <= '0;
      skid_imm_q <= '0;
      main_pc_q  <= '0;
      skid_pc_q  <= '0;
      rdy_q      <= 1'b1;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      main_f_q   <= main_f_d;
      skid_f_q   <= skid_f_d;
      main_imm_q <= main_imm_d;
      skid_imm_q <= skid_imm_d;
      main_pc_q  <= main_pc_d;
      skid_pc_q  <= skid_pc_d;
      rdy_q      <= rdy_d;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = main_v_q;
  assign bus.out_pc          = main_pc_q;
  assign bus.out_rs1         = main_f_q.rs1;
  assign bus.out_rs2         = main_f_q.rs2;
  assign bus.out_rd          = main_f_q.rd;
  assign bus.out_func3       = main_f_q.func3;
  assign bus.out_func7       = main_f_q.func7;
  assign bus.out_imm         = main_imm_q;
  assign bus.out_field_valid = main_f_q.field_valid;
  assign bus.out_type        = main_f_q.itype;
  assign bus.out_illegal     = main_f_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus stall, flush and
// reset-during-stall sequences, on an M_EXT=1 and an M_EXT=0 instance.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus1 ();
  decode_stage_if #(.XLEN(32)) bus0 ();

  decode_stage #(.XLEN(32), .M_EXT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  decode_stage #(.XLEN(32), .M_EXT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [5:0]  fv;
    logic        ill0;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] instr, input logic [2:0] typ,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [5:0] fv, input logic ill0);
    vec_t v;
    v.instr = instr; v.typ = typ; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.fv = fv; v.ill0 = ill0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bus1.in_valid = v;  bus0.in_valid = v;
    bus1.in_instr = instr; bus0.in_instr = instr;
    bus1.in_pc = pc;    bus0.in_pc = pc;
    bus1.out_ready = ordy; bus0.out_ready = ordy;
    bus1.flush = fl;    bus0.flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // type, rd, rs1, rs2, f3, f7, imm, fv, illegal-on-M_EXT=0
    vecs[0]  = mk(32'h00108093, 3'd1, 5'd1,  5'd1, 5'd1, 3'd0, 7'h00, 32'h00000001, 6'b101011, 1'b0);
    vecs[1]  = mk(32'hFFDFF1EF, 3'd5, 5'd3,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 6'b100001, 1'b0);
    vecs[2]  = mk(32'h02208033, 3'd0, 5'd0,  5'd1, 5'd2, 3'd0, 7'h01, 32'h00000000, 6'b011111, 1'b1);
    vecs[3]  = mk(32'h00000000, 3'd7, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 6'b000000, 1'b1);
    vecs[4]  = mk(32'hFE512C23, 3'd2, 5'd0,  5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFFFFF8, 6'b101110, 1'b0);
    vecs[5]  = mk(32'h00208463, 3'd3, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'h00000008, 6'b101110, 1'b0);
    vecs[6]  = mk(32'h123452B7, 3'd4, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 6'b100001, 1'b0);
    vecs[7]  = mk(32'hFFFFF517, 3'd4, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 6'b100001, 1'b0);
    vecs[8]  = mk(32'h00000073, 3'd6, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 6'b101011, 1'b0);
    vecs[9]  = mk(32'h0FF0000F, 3'd6, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h000000FF, 6'b101011, 1'b0);
    vecs[10] = mk(32'h40315093, 3'd1, 5'd1,  5'd2, 5'd0, 3'd5, 7'h00, 32'h00000403, 6'b101011, 1'b0);
    vecs[11] = mk(32'h40311093, 3'd7, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 6'b000000, 1'b1);
    vecs[12] = mk(32'h402081B3, 3'd0, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 6'b011111, 1'b0);
    vecs[13] = mk(32'h402091B3, 3'd7, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 6'b000000, 1'b1);
    vecs[14] = mk(32'h00108091, 3'd7, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 6'b000000, 1'b1);
    vecs[15] = mk(32'h0000007F, 3'd7, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 6'b000000, 1'b1);
    vecs[16] = mk(32'h00412083, 3'd1, 5'd1,  5'd2, 5'd0, 3'd2, 7'h00, 32'h00000004, 6'b101011, 1'b0);
    vecs[17] = mk(32'h00008067, 3'd1, 5'd0,  5'd1, 5'd0, 3'd0, 7'h00, 32'h00000000, 6'b101011, 1'b0);

    // Reset state
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", bus1.in_ready, 1'b0);
    chk("rst_out_valid", bus1.out_valid, 1'b0);
    chk("rst_out_type", bus1.out_type, 3'd0);
    chk("rst_out_imm", bus1.out_imm, 32'h0);
    chk("rst_out_pc", bus1.out_pc, 32'h0);
    chk("rst_out_illegal", bus1.out_illegal, 1'b0);
    chk("rst_out_fv", bus1.out_field_valid, 6'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus1.in_ready, 1'b1);

    // Decode table, one instruction per cycle with downstream always ready
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
      chk($sformatf("v%0d_in_ready", i), bus1.in_ready, 1'b1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("v%0d_valid", i), bus1.out_valid, 1'b1);
      chk($sformatf("v%0d_pc", i), bus1.out_pc, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_type", i), bus1.out_type, vecs[i].typ);
      chk($sformatf("v%0d_illegal", i), bus1.out_illegal, vecs[i].typ == 3'd7);
      chk($sformatf("v%0d_fv", i), bus1.out_field_valid, vecs[i].fv);
      chk($sformatf("v%0d_imm", i), bus1.out_imm, vecs[i].imm);
      if (vecs[i].fv[0]) chk($sformatf("v%0d_rd", i), bus1.out_rd, vecs[i].rd);
      if (vecs[i].fv[1]) chk($sformatf("v%0d_rs1", i), bus1.out_rs1, vecs[i].rs1);
      if (vecs[i].fv[2]) chk($sformatf("v%0d_rs2", i), bus1.out_rs2, vecs[i].rs2);
      if (vecs[i].fv[3]) chk($sformatf("v%0d_func3", i), bus1.out_func3, vecs[i].f3);
      if (vecs[i].fv[4]) chk($sformatf("v%0d_func7", i), bus1.out_func7, vecs[i].f7);
      chk($sformatf("v%0d_m0_illegal", i), bus0.out_illegal, vecs[i].ill0);
      chk($sformatf("v%0d_m0_type", i), bus0.out_type, vecs[i].ill0 ? 3'd7 : vecs[i].typ);
      chk($sformatf("v%0d_m0_pc", i), bus0.out_pc, 32'h1000 + 32'(i * 4));
    end
    tick();
    chk("table_drained", bus1.out_valid, 1'b0);

    // Stall: three back-to-back with out_ready low, then release
    drive(1'b1, 32'h00100093, 32'h2000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00200113, 32'h2004, 1'b0, 1'b0);
    chk("stall_in_ready_b", bus1.in_ready, 1'b1);
    tick();
    drive(1'b1, 32'h00300193, 32'h2008, 1'b0, 1'b0);
    chk("stall_in_ready_full", bus1.in_ready, 1'b0);
    chk("stall_out_pc_a", bus1.out_pc, 32'h2000);
    tick();
    chk("stall_hold_in_ready", bus1.in_ready, 1'b0);
    chk("stall_hold_valid", bus1.out_valid, 1'b1);
    chk("stall_hold_pc", bus1.out_pc, 32'h2000);
    chk("stall_hold_rd", bus1.out_rd, 5'd1);
    chk("stall_hold_imm", bus1.out_imm, 32'h1);
    drive(1'b1, 32'h00300193, 32'h2008, 1'b1, 1'b0);
    tick();
    chk("rel_b_valid", bus1.out_valid, 1'b1);
    chk("rel_b_pc", bus1.out_pc, 32'h2004);
    chk("rel_b_rd", bus1.out_rd, 5'd2);
    chk("rel_b_in_ready", bus1.in_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("rel_c_valid", bus1.out_valid, 1'b1);
    chk("rel_c_pc", bus1.out_pc, 32'h2008);
    chk("rel_c_imm", bus1.out_imm, 32'h3);
    tick();
    chk("rel_empty", bus1.out_valid, 1'b0);

    // Flush with skid full and a simultaneous offer
    drive(1'b1, 32'h00100093, 32'h3000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00200113, 32'h3004, 1'b0, 1'b0);
    tick();
    chk("fl_pre_in_ready", bus1.in_ready, 1'b0);
    drive(1'b1, 32'h00300193, 32'h3008, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("fl_out_valid", bus1.out_valid, 1'b0);
    chk("fl_in_ready", bus1.in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fl_quiet%0d", k), bus1.out_valid, 1'b0);
    end

    // Reset pulse during a stall with both entries occupied
    drive(1'b1, 32'h00100093, 32'h4000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00200113, 32'h4004, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00300193, 32'h4008, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rp_in_ready_during", bus1.in_ready, 1'b0);
    tick();
    chk("rp_out_valid", bus1.out_valid, 1'b0);
    chk("rp_out_pc", bus1.out_pc, 32'h0);
    chk("rp_out_rd", bus1.out_rd, 5'd0);
    chk("rp_out_imm", bus1.out_imm, 32'h0);
    chk("rp_out_fv", bus1.out_field_valid, 6'b0);
    chk("rp_in_ready_held", bus1.in_ready, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk("rp_in_ready_after", bus1.in_ready, 1'b1);
    tick();
    chk("rp_no_stale", bus1.out_valid, 1'b0);
    drive(1'b1, 32'hFFDFF1EF, 32'h5000, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("rp_resume_pc", bus1.out_pc, 32'h5000);
    chk("rp_resume_type", bus1.out_type, 3'd5);
    chk("rp_resume_imm", bus1.out_imm, 32'hFFFFFFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
